// File: rtl/icache_blocking_dm.sv
// Blocking direct-mapped VIPT L1 I-cache: set indexed by idx, tag checked against pa one cycle later.
// Optional macro ICACHE_PERF_CNT_EN adds cached-lookup hit/miss counters.
module icache_blocking_dm #(
  parameter int LINE_WORDS = 4,
  parameter int SET_NUM    = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_icache,
  input  logic [11:0] icache_idx,
  input  logic [2:0]  icache_op,
  input  logic        icache_is_cached,
  input  logic [31:0] icache_pa,
  output logic [31:0] icache_data,
  output logic        icache_busy,
  output logic        icache_data_valid,
  output logic        rd_req,
  output logic [31:0] rd_addr,
  output logic [7:0]  rd_len,
  input  logic        rd_rdy,
  input  logic        ret_valid,
  input  logic        ret_last,
  input  logic [31:0] ret_data
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0] perf_hit_cnt,
  output logic [31:0] perf_miss_cnt
`endif
);
  localparam int OFF_W  = $clog2(LINE_WORDS * 4);
  localparam int WORD_W = $clog2(LINE_WORDS);
  localparam int SET_W  = $clog2(SET_NUM);
  localparam int TAG_W  = 32 - OFF_W - SET_W;

  localparam logic [2:0] OP_LOOKUP   = 3'd1;
  localparam logic [2:0] OP_IDX_INIT = 3'd2;
  localparam logic [2:0] OP_IDX_INV  = 3'd3;
  localparam logic [2:0] OP_HIT_INV  = 3'd4;

  typedef enum logic [2:0] {IDLE, S1_CHK, MISS, REFILL, RESP} state_t;

  state_t              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [SET_W-1:0]    set_q, set_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [WORD_W-1:0]   cnt_q, cnt_d;
  logic [31:2]         pa_q, pa_d;
  logic                cached_q, cached_d;
  logic [SET_NUM-1:0]  valid_q, valid_d;
  logic [31:0]         resp_data_q, resp_data_d;
  logic [31:0]         line_q [LINE_WORDS];
  logic [31:0]         line_d [LINE_WORDS];
  logic [31:0]         line_fill [LINE_WORDS];

  logic [TAG_W-1:0]    tag_ram  [SET_NUM];
  logic [31:0]         data_ram [SET_NUM][LINE_WORDS];

  logic        tag_match, hit, is_lookup, is_cacop, s1_done, req_ok, refill_we;
  logic [31:0] word_rd;
  logic        unused_ok;

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] perf_hit_q, perf_hit_d, perf_miss_q, perf_miss_d;
  assign perf_hit_cnt  = perf_hit_q;
  assign perf_miss_cnt = perf_miss_q;
`endif

  assign unused_ok = &{1'b0, icache_idx[1:0], icache_pa[1:0]};

  // Arrays are read with the latched set in S1, so a cacop clear from the previous cycle is already visible.
  assign tag_match = valid_q[set_q] && (tag_ram[set_q] == pa_q[31:OFF_W+SET_W]);
  assign is_lookup = (op_q == OP_LOOKUP);
  assign is_cacop  = (op_q == OP_IDX_INIT) || (op_q == OP_IDX_INV) || (op_q == OP_HIT_INV);
  assign hit       = is_lookup && cached_q && tag_match;
  assign s1_done   = is_cacop || hit;
  assign word_rd   = data_ram[set_q][word_q];
  assign req_ok    = (icache_op == OP_LOOKUP) || (icache_op == OP_IDX_INIT) ||
                     (icache_op == OP_IDX_INV) || (icache_op == OP_HIT_INV);

  always_comb begin
    line_fill         = line_q;
    line_fill[cnt_q]  = ret_data;
  end

  always_comb begin
    state_d           = state_q;
    op_d              = op_q;
    set_d             = set_q;
    word_d            = word_q;
    cnt_d             = cnt_q;
    pa_d              = pa_q;
    cached_d          = cached_q;
    valid_d           = valid_q;
    resp_data_d       = resp_data_q;
    line_d            = line_q;
    refill_we         = 1'b0;
    icache_busy       = 1'b0;
    icache_data_valid = 1'b0;
    icache_data       = 32'h0;
    rd_req            = 1'b0;
    rd_addr           = 32'h0;
    rd_len            = 8'h0;
`ifdef ICACHE_PERF_CNT_EN
    perf_hit_d        = perf_hit_q;
    perf_miss_d       = perf_miss_q;
`endif

    case (state_q)
      S1_CHK: begin
        icache_busy = !(s1_done && !stall_icache);
        if (hit) begin
          icache_data_valid = 1'b1;
          icache_data       = word_rd;
        end
        if ((op_q == OP_IDX_INIT) || (op_q == OP_IDX_INV) ||
            ((op_q == OP_HIT_INV) && tag_match)) begin
          valid_d[set_q] = 1'b0;
        end
`ifdef ICACHE_PERF_CNT_EN
        if (is_lookup && cached_q) begin
          if (hit) perf_hit_d  = perf_hit_q + 32'd1;
          else     perf_miss_d = perf_miss_q + 32'd1;
        end
`endif
        if (!s1_done) begin
          state_d = MISS;
        end else if (hit && stall_icache) begin
          // Park a stalled hit in RESP so data stays stable until consumed.
          state_d     = RESP;
          resp_data_d = word_rd;
        end else begin
          state_d = IDLE;
        end
      end
      MISS: begin
        icache_busy = 1'b1;
        rd_req      = 1'b1;
        rd_addr     = cached_q ? {pa_q[31:OFF_W], {OFF_W{1'b0}}} : {pa_q[31:2], 2'b00};
        rd_len      = cached_q ? 8'(LINE_WORDS - 1) : 8'h0;
        if (rd_rdy) begin
          state_d = REFILL;
          cnt_d   = '0;
        end
      end
      REFILL: begin
        icache_busy = 1'b1;
        if (ret_valid) begin
          line_d = line_fill;
          cnt_d  = cnt_q + WORD_W'(1);
          if (ret_last) begin
            state_d     = RESP;
            resp_data_d = cached_q ? line_fill[word_q] : ret_data;
            if (cached_q) begin
              refill_we      = 1'b1;
              valid_d[set_q] = 1'b1;
            end
          end
        end
      end
      RESP: begin
        icache_busy       = 1'b1;
        icache_data_valid = 1'b1;
        icache_data       = resp_data_q;
        if (!stall_icache) state_d = IDLE;
      end
      default: ;
    endcase

    if (req_ok && !icache_busy && !stall_icache) begin
      state_d  = S1_CHK;
      op_d     = icache_op;
      set_d    = icache_idx[11:OFF_W];
      word_d   = icache_idx[OFF_W-1:2];
      pa_d     = icache_pa[31:2];
      cached_d = icache_is_cached;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= 3'h0;
      set_q       <= '0;
      word_q      <= '0;
      cnt_q       <= '0;
      pa_q        <= '0;
      cached_q    <= 1'b0;
      valid_q     <= '0;
      resp_data_q <= 32'h0;
      line_q      <= '{default: 32'h0};
`ifdef ICACHE_PERF_CNT_EN
      perf_hit_q  <= 32'h0;
      perf_miss_q <= 32'h0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      set_q       <= set_d;
      word_q      <= word_d;
      cnt_q       <= cnt_d;
      pa_q        <= pa_d;
      cached_q    <= cached_d;
      valid_q     <= valid_d;
      resp_data_q <= resp_data_d;
      line_q      <= line_d;
`ifdef ICACHE_PERF_CNT_EN
      perf_hit_q  <= perf_hit_d;
      perf_miss_q <= perf_miss_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (refill_we) begin
      tag_ram[set_q] <= pa_q[31:OFF_W+SET_W];
      for (int w = 0; w < LINE_WORDS; w++) data_ram[set_q][w] <= line_fill[w];
    end
  end
endmodule

// File: tb/tb_icache_blocking_dm.sv
// Directed bench for icache_blocking_dm: misses, hits, uncached, stall, cacops, reset mid-refill.
module tb_icache_blocking_dm;
  logic        clk = 1'b0;
  logic        rst;
  logic        stall_icache;
  logic [11:0] icache_idx;
  logic [2:0]  icache_op;
  logic        icache_is_cached;
  logic [31:0] icache_pa;
  logic [31:0] icache_data;
  logic        icache_busy;
  logic        icache_data_valid;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic [7:0]  rd_len;
  logic        rd_rdy;
  logic        ret_valid;
  logic        ret_last;
  logic [31:0] ret_data;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] perf_hit_cnt, perf_miss_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  icache_blocking_dm dut (
    .clk(clk), .rst(rst), .stall_icache(stall_icache),
    .icache_idx(icache_idx), .icache_op(icache_op), .icache_is_cached(icache_is_cached),
    .icache_pa(icache_pa), .icache_data(icache_data), .icache_busy(icache_busy),
    .icache_data_valid(icache_data_valid), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_len(rd_len), .rd_rdy(rd_rdy), .ret_valid(ret_valid), .ret_last(ret_last),
    .ret_data(ret_data)
`ifdef ICACHE_PERF_CNT_EN
    , .perf_hit_cnt(perf_hit_cnt), .perf_miss_cnt(perf_miss_cnt)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [2:0] op, input logic [11:0] idx, input logic [31:0] pa,
                     input logic cached);
    icache_op        = op;
    icache_idx       = idx;
    icache_pa        = pa;
    icache_is_cached = cached;
  endtask

  task automatic nop();
    icache_op = 3'd0;
  endtask

  // Waits (bounded) for rd_req, checks it, grants it, returns len+1 beats; ends in RESP.
  task automatic serve(input string tg, input logic [31:0] a, input logic [7:0] l,
                       input logic [31:0] d0, input logic [31:0] d1,
                       input logic [31:0] d2, input logic [31:0] d3);
    logic [31:0] d [4];
    int w;
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    w = 0;
    while (!rd_req && w < 20) begin
      cyc();
      w++;
    end
    check_eq({tg, "_rd_req"}, 32'(rd_req), 32'd1);
    check_eq({tg, "_rd_addr"}, rd_addr, a);
    check_eq({tg, "_rd_len"}, 32'(rd_len), 32'(l));
    rd_rdy = 1'b1;
    cyc();
    rd_rdy = 1'b0;
    for (int k = 0; k <= int'(l); k++) begin
      ret_valid = 1'b1;
      ret_data  = d[k];
      ret_last  = (k == int'(l));
      cyc();
    end
    ret_valid = 1'b0;
    ret_last  = 1'b0;
  endtask

  task automatic check_resp(input string tg, input logic [31:0] exp);
    check_eq({tg, "_dv"}, 32'(icache_data_valid), 32'd1);
    check_eq({tg, "_data"}, icache_data, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; stall_icache = 1'b0; rd_rdy = 1'b0;
    ret_valid = 1'b0; ret_last = 1'b0; ret_data = 32'h0;
    req(3'd0, 12'h000, 32'h0, 1'b1);
    cyc(); cyc();
    check_eq("rst_busy", 32'(icache_busy), 32'd0);
    check_eq("rst_dv", 32'(icache_data_valid), 32'd0);
    check_eq("rst_data", icache_data, 32'd0);
    check_eq("rst_rd_req", 32'(rd_req), 32'd0);
    check_eq("rst_rd_addr", rd_addr, 32'd0);
    check_eq("rst_rd_len", 32'(rd_len), 32'd0);
    rst = 1'b0;
    cyc();

    // cold miss then hit on last word of the refilled line
    req(3'd1, 12'h000, 32'h1C000000, 1'b1);
    cyc();
    check_eq("cold_busy", 32'(icache_busy), 32'd1);
    check_eq("cold_dv", 32'(icache_data_valid), 32'd0);
    nop();
    serve("cold", 32'h1C000000, 8'd3, 32'h11, 32'h22, 32'h33, 32'h44);
    check_resp("cold_resp", 32'h11);
    check_eq("cold_resp_busy", 32'(icache_busy), 32'd1);
    cyc();
    check_eq("cold_idle_busy", 32'(icache_busy), 32'd0);
    check_eq("cold_idle_dv", 32'(icache_data_valid), 32'd0);
    req(3'd1, 12'h00C, 32'h1C00000C, 1'b1);
    cyc();
    check_resp("rehit", 32'h44);
    check_eq("rehit_busy", 32'(icache_busy), 32'd0);
    check_eq("rehit_rd_req", 32'(rd_req), 32'd0);
    nop();
    cyc();

    // back-to-back hits, one per cycle
    req(3'd1, 12'h000, 32'h1C000000, 1'b1);
    cyc();
    check_resp("b2b0", 32'h11);
    req(3'd1, 12'h004, 32'h1C000004, 1'b1);
    cyc();
    check_resp("b2b1", 32'h22);
    check_eq("b2b1_rd_req", 32'(rd_req), 32'd0);
    req(3'd1, 12'h008, 32'h1C000008, 1'b1);
    cyc();
    check_resp("b2b2", 32'h33);
    nop();
    cyc();
    check_eq("b2b_end_dv", 32'(icache_data_valid), 32'd0);
    check_eq("b2b_end_rd_req", 32'(rd_req), 32'd0);

    // uncached single-word reads, each goes to memory
    for (int r = 0; r < 2; r++) begin
      req(3'd1, 12'h004, 32'h1FAF0004, 1'b0);
      cyc();
      check_eq("unc_busy", 32'(icache_busy), 32'd1);
      nop();
      serve("unc", 32'h1FAF0004, 8'd0, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0);
      check_resp("unc_resp", 32'hDEADBEEF);
      cyc();
    end

    // stall holds a hit response for three cycles; a waiting request is not taken
    req(3'd1, 12'h008, 32'h1C000008, 1'b1);
    cyc();
    stall_icache = 1'b1;
    req(3'd1, 12'h004, 32'h1C000004, 1'b1);
    #1;
    for (int s = 0; s < 3; s++) begin
      check_resp("stall", 32'h33);
      check_eq("stall_busy", 32'(icache_busy), 32'd1);
      cyc();
    end
    stall_icache = 1'b0;
    #1;
    check_resp("unstall", 32'h33);
    cyc();
    check_eq("unstall_idle_dv", 32'(icache_data_valid), 32'd0);
    check_eq("unstall_idle_busy", 32'(icache_busy), 32'd0);
    cyc();
    check_resp("after_stall", 32'h22);
    nop();
    cyc();

    // HIT_INVALIDATE with a different tag keeps the line
    req(3'd4, 12'h000, 32'h1D000000, 1'b1);
    cyc();
    check_eq("hinv_mis_dv", 32'(icache_data_valid), 32'd0);
    check_eq("hinv_mis_busy", 32'(icache_busy), 32'd0);
    nop();
    cyc();
    check_eq("hinv_mis_rd_req", 32'(rd_req), 32'd0);
    req(3'd1, 12'h000, 32'h1C000000, 1'b1);
    cyc();
    check_resp("hinv_mis_hit", 32'h11);
    nop();
    cyc();

    // HIT_INVALIDATE with the matching tag drops it
    req(3'd4, 12'h000, 32'h1C000000, 1'b1);
    cyc();
    nop();
    cyc();
    req(3'd1, 12'h000, 32'h1C000000, 1'b1);
    cyc();
    check_eq("hinv_match_busy", 32'(icache_busy), 32'd1);
    check_eq("hinv_match_dv", 32'(icache_data_valid), 32'd0);
    nop();
    serve("hinv", 32'h1C000000, 8'd3, 32'h55, 32'h66, 32'h77, 32'h88);
    check_resp("hinv_resp", 32'h55);
    cyc();

    // fill set 5, then uncached IDX_INIT right behind a hit clears it
    req(3'd1, 12'h050, 32'h1C000050, 1'b1);
    cyc();
    nop();
    serve("s5", 32'h1C000050, 8'd3, 32'hA1, 32'hA2, 32'hA3, 32'hA4);
    check_resp("s5_resp", 32'hA1);
    cyc();
    req(3'd1, 12'h05C, 32'h1C00005C, 1'b1);
    cyc();
    check_resp("s5_hit", 32'hA4);
    req(3'd2, 12'h050, 32'h00000000, 1'b0);
    cyc();
    check_eq("init_dv", 32'(icache_data_valid), 32'd0);
    check_eq("init_busy", 32'(icache_busy), 32'd0);
    check_eq("init_rd_req", 32'(rd_req), 32'd0);
    nop();
    cyc();
    req(3'd1, 12'h050, 32'h1C000050, 1'b1);
    cyc();
    check_eq("init_miss_busy", 32'(icache_busy), 32'd1);
    nop();
    serve("s5b", 32'h1C000050, 8'd3, 32'hB1, 32'hB2, 32'hB3, 32'hB4);
    check_resp("s5b_resp", 32'hB1);
    cyc();

    // ops 5-7 are ignored
    req(3'd7, 12'h020, 32'h1C000020, 1'b1);
    cyc();
    check_eq("op7_busy", 32'(icache_busy), 32'd0);
    check_eq("op7_dv", 32'(icache_data_valid), 32'd0);
    cyc();
    check_eq("op7_rd_req", 32'(rd_req), 32'd0);
    nop();
    cyc();

    // reset after two of four refill beats
    req(3'd1, 12'h020, 32'h1C000020, 1'b1);
    cyc();
    nop();
    cyc();
    check_eq("mr_rd_req", 32'(rd_req), 32'd1);
    check_eq("mr_rd_addr", rd_addr, 32'h1C000020);
    rd_rdy = 1'b1;
    cyc();
    rd_rdy = 1'b0;
    ret_valid = 1'b1; ret_data = 32'hC1;
    cyc();
    ret_data = 32'hC2;
    cyc();
    ret_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_eq("mr_busy", 32'(icache_busy), 32'd0);
    check_eq("mr_dv", 32'(icache_data_valid), 32'd0);
    check_eq("mr_rd_req0", 32'(rd_req), 32'd0);
    cyc();
    check_eq("mr_data", icache_data, 32'd0);
    check_eq("mr_rd_addr0", rd_addr, 32'd0);
    check_eq("mr_rd_len0", 32'(rd_len), 32'd0);
    rst = 1'b0;
    cyc();
    req(3'd1, 12'h000, 32'h1C000000, 1'b1);
    cyc();
    check_eq("post_rst_miss", 32'(icache_busy), 32'd1);
    nop();
    serve("post", 32'h1C000000, 8'd3, 32'h1, 32'h2, 32'h3, 32'h4);
    check_resp("post_resp", 32'h1);
    cyc();
    req(3'd1, 12'h004, 32'h1C000004, 1'b1);
    cyc();
    check_resp("post_hit", 32'h2);
    nop();
    cyc();
`ifdef ICACHE_PERF_CNT_EN
    check_eq("perf_hit", perf_hit_cnt, 32'd1);
    check_eq("perf_miss", perf_miss_cnt, 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/icache_blocking_dm.md
Name: icache_blocking_dm

Overview:
- Direct-mapped, blocking L1 instruction cache that consumes the front-end fetch request (icache_idx/op/pa/is_cached/stall) and returns icache_data/busy/data_valid to the fetch-2 stage.
- VIPT: the set is indexed by the 12-bit untranslated idx; the tag is compared against the translated pa one cycle later.
- Misses and uncached fetches go to a simple burst-read memory port toward the AXI bridge.

Parameters:
- LINE_WORDS, 4, 32-bit words per line (power of 2).
- SET_NUM, 256, number of sets. Constraint: log2(LINE_WORDS*4)+log2(SET_NUM) == 12.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- stall_icache  in  1  downstream stalled; hold response and accept nothing new
- icache_idx  in  12  virtual index: [11:offset] set, [offset-1:2] word
- icache_op  in  3  0 NOP, 1 LOOKUP, 2 IDX_INIT, 3 IDX_INVALIDATE, 4 HIT_INVALIDATE; 5-7 treated as NOP
- icache_is_cached  in  1  0 = bypass cache, single-word read
- icache_pa  in  32  physical address, same cycle as idx
- icache_data  out  32  instruction word
- icache_busy  out  1  request not accepted this cycle
- icache_data_valid  out  1  icache_data valid
- rd_req  out  1  memory read request
- rd_addr  out  32  line-aligned (cached) or word address (uncached)
- rd_len  out  8  beats-1: LINE_WORDS-1 or 0
- rd_rdy  in  1  request accepted when rd_req&rd_rdy
- ret_valid  in  1  return beat valid
- ret_last  in  1  final beat
- ret_data  in  32  beat data

Behaviour:
- Reset: all valid bits 0; FSM IDLE; icache_busy=0, icache_data_valid=0, icache_data=0, rd_req=0, rd_addr=0, rd_len=0; any in-flight memory transaction is abandoned (memory side is reset together).
- Accept: in cycle t when op!=NOP && !icache_busy && !stall_icache. Latch op/idx/pa/is_cached into S1; read tag, valid and data at the set.
- FSM states: IDLE, S1_CHK, MISS, REFILL, RESP.
- S1_CHK (t+1), LOOKUP, cached:
  - Hit = valid && tag==pa[31:12] → data_valid=1, data=word[idx word].
  - If !stall in t+1, a new request may be accepted in t+1 (1 fetch/cycle throughput).
- S1_CHK, cached miss or uncached → MISS with busy=1.
- MISS: rd_req=1 holding addr/len until rd_rdy.
  - addr = {pa[31:offset],0} with len=LINE_WORDS-1 (cached), or {pa[31:2],00} with len=0 (uncached).
  - Then → REFILL.
- REFILL: beats fill line buffer at ascending word index.
  - ret_last → RESP; cached: write line, tag, valid=1 in the same edge.
  - ret_valid outside REFILL is ignored.
- RESP: data_valid=1, data=requested word (uncached: the single beat); busy=1. Leave to IDLE on the first cycle with !stall.
- Stall: while stall_icache=1 with a pending S1 response, data_valid and data hold and busy=1. The response is consumed on the first cycle stall=0.
- Cacop ops:
  - Complete in S1_CHK; data_valid=0, no memory traffic.
  - IDX_INIT and IDX_INVALIDATE clear the set's valid bit.
  - HIT_INVALIDATE clears it only on tag match.
  - An uncached cacop is still a tag op.
- Set conflicts: a write in RESP blocks acceptance, so there are no read/write set conflicts.
- Unsupported ops: op 5-7 are never accepted and busy stays 0.

Optional Feature:
- ICACHE_PERF_CNT_EN defined: adds output ports perf_hit_cnt[31:0] and perf_miss_cnt[31:0].
  - Each increments once per cached LOOKUP resolution in S1_CHK; wraps at 2^32; reset to 0.
  - Uncached fetches and cacop ops are not counted.
- Undefined: these ports and their counters are absent; behaviour is otherwise identical.

Test Plan:
- Cold miss: LOOKUP pa=0x1C000000, idx=0x000, cached → busy t+1, rd_req addr=0x1C000000 len=3; return 0x11,0x22,0x33,0x44 → data_valid with data=0x11; re-LOOKUP pa=0x1C00000C → hit next cycle, data=0x44.
- Back-to-back hits: LOOKUP 0x...0, 0x...4, 0x...8 on consecutive cycles → data_valid 3 consecutive cycles, no rd_req.
- Uncached: is_cached=0, pa=0x1FAF0004 → rd_addr=0x1FAF0004 len=0, ret 0xDEADBEEF → data_valid=1 with data=0xDEADBEEF; a repeat access again issues rd_req.
- Stall hold: hit response with stall_icache=1 for 3 cycles → data_valid/data constant, busy=1, no acceptance; released on stall=0.
- Cacop: fill set 0; HIT_INVALIDATE pa mismatch → next LOOKUP hits; HIT_INVALIDATE match → next LOOKUP misses; IDX_INIT set 5 → valid cleared.
- Reset mid-refill: assert rst after 2 of 4 beats → all outputs at reset values next cycle; prior lines miss after reset.
